add_v_pipe: RTL

Pipelined, parametrised successor to the combinational overflow-flag adder. It computes A ± B with carry/borrow-in, carry-out and 2's-complement overflow, with optional saturation. The addition is split into `stages` equal chunks, one chunk per clock, with the carry registered between chunks. The block sits between valid/ready-handshaked datapath units and accepts one operation per cycle.

---
 rtl/lau_pkg.sv | 19 +
 rtl/add_v_pipe_addcv.sv | 75 +++++++
 rtl/add_v_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lau_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lau_pkg
// Description : Shared types for the arithmetic units. speed_e selects the
//               carry-network topology of the prefix adders.
// Revision    : 1.0 - initial release
// ============================================================================
package lau_pkg;

  // FAST  : log-depth parallel-prefix carry network
  // others: serial carry chain (smallest, slowest)
  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    MEDIUM = 2'd1,
    FAST   = 2'd2
  } speed_e;

endpackage
`default_nettype wire

// File: rtl/add_v_pipe_addcv.sv
`default_nettype none
// ============================================================================
// Module      : AddCV
// Description : Combinational width-bit adder with carry-in, carry-out and
//               2's-complement overflow. The carry network is selected by
//               the speed parameter.
// Ports       : A, B  in  width  operands
//               CI    in  1      carry-in
//               S     out width  sum
//               C     out 1      carry-out of the MSB
//               V     out 1      signed overflow (carry into MSB ^ carry out)
// Revision    : 1.0 - initial release
// ============================================================================
module AddCV
  import lau_pkg::*;
#(
  parameter int     width = 2,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic [width-1:0] S,
  output logic             C,
  output logic             V
);

  // w_carry[i] is the carry into bit i; w_carry[width] is the carry-out.
  logic [width:0] w_carry;

  // Kogge-Stone prefix. The carry-in is folded into bit 0's generate so the
  // final group-generate of bit i is directly the carry out of bit i.
  function automatic logic [width:0] ks_carries(input logic [width-1:0] a,
                                                input logic [width-1:0] b,
                                                input logic             ci);
    logic [width-1:0] g, p, gn, pn;
    g    = a & b;
    p    = a ^ b;
    g[0] = g[0] | (p[0] & ci);
    for (int d = 1; d < width; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < width; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return {g, ci};
  endfunction

  function automatic logic [width:0] rc_carries(input logic [width-1:0] a,
                                                input logic [width-1:0] b,
                                                input logic             ci);
    logic [width:0] c;
    c[0] = ci;
    for (int i = 0; i < width; i++) begin
      c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    return c;
  endfunction

  if (speed == FAST) begin : g_kogge
    assign w_carry = ks_carries(A, B, CI);
  end else begin : g_ripple
    assign w_carry = rc_carries(A, B, CI);
  end

  assign S = A ^ B ^ w_carry[width-1:0];
  assign C = w_carry[width];
  assign V = w_carry[width] ^ w_carry[width-1];

endmodule
`default_nettype wire

// File: rtl/add_v_pipe.sv
`default_nettype none
// ============================================================================
// Module      : add_v_pipe
// Description : Pipelined A +/- B +/- CI with carry-out, signed overflow and
//               optional saturation. The add is cut into `stages` chunks of
//               width/stages bits, one chunk per clock, carry registered
//               between chunks. Valid/ready with a single global enable.
// Ports       : CLK       in  1      clock, rising edge
//               RST       in  1      asynchronous reset, active-high
//               InValid   in  1      operands valid
//               InReady   out 1      block can accept (combinational)
//               A, B      in  width  operands
//               CI        in  1      carry-in / borrow-in
//               Sub       in  1      0: A+B+CI   1: A-B-CI
//               Sat       in  1      saturate on signed overflow
//               OutValid  out 1      result valid
//               OutReady  in  1      downstream accepts
//               S         out width  result
//               V         out 1      signed overflow of unsaturated result
//               C         out 1      carry-out (Sub=1: 1 = no borrow)
// Revision    : 1.0 - initial release
// ============================================================================
module add_v_pipe
  import lau_pkg::*;
#(
  parameter int     width  = 32,
  parameter int     stages = 4,
  parameter speed_e speed  = FAST
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  input  logic             Sub,
  input  logic             Sat,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [width-1:0] S,
  output logic             V,
  output logic             C
);

  localparam int               c_cw  = width / stages;
  localparam logic [width-1:0] c_max = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] c_min = {1'b1, {(width-1){1'b0}}};

  logic             w_en;
  logic [width-1:0] w_b_eff;
  logic             w_ci_eff;

  logic             r_out_vld;
  logic [width-1:0] r_s;
  logic             r_v;
  logic             r_c;

  // Whole pipeline advances together; it only stalls when a result is
  // presented and not taken.
  assign w_en     = ~r_out_vld | OutReady;
  assign InReady  = w_en;

  // Subtraction as A + ~B + ~CI, so only stage 0 needs to know about Sub.
  assign w_b_eff  = B ^ {width{Sub}};
  assign w_ci_eff = CI ^ Sub;

  for (genvar k = 0; k < stages; k++) begin : g_stage
    // Operand bits not yet consumed on entry to this stage (incl. chunk k).
    localparam int c_rw = width - k * c_cw;

    logic [c_rw-1:0]       w_a_in;
    logic [c_rw-1:0]       w_b_in;
    logic                  w_ci;
    logic                  w_vld;
    logic                  w_sat;
    logic [c_cw-1:0]       w_sum;
    logic                  w_co;
    logic [(k+1)*c_cw-1:0] w_s_acc;

    if (k == 0) begin : g_src_port
      assign w_a_in  = A;
      assign w_b_in  = w_b_eff;
      assign w_ci    = w_ci_eff;
      assign w_vld   = InValid;
      assign w_sat   = Sat;
      assign w_s_acc = w_sum;
    end else begin : g_src_prev
      assign w_a_in  = g_stage[k-1].g_mid.r_a_rest;
      assign w_b_in  = g_stage[k-1].g_mid.r_b_rest;
      assign w_ci    = g_stage[k-1].g_mid.r_c;
      assign w_vld   = g_stage[k-1].g_mid.r_vld;
      assign w_sat   = g_stage[k-1].g_mid.r_sat;
      assign w_s_acc = {w_sum, g_stage[k-1].g_mid.r_s_acc};
    end

    if (k < stages - 1) begin : g_mid
      logic [c_rw-c_cw-1:0]  r_a_rest;
      logic [c_rw-c_cw-1:0]  r_b_rest;
      logic [(k+1)*c_cw-1:0] r_s_acc;
      logic                  r_vld;
      logic                  r_c;
      logic                  r_sat;
      logic                  w_v_unused;

      AddCV #(.width(c_cw), .speed(speed)) u_add (
        .A  (w_a_in[c_cw-1:0]),
        .B  (w_b_in[c_cw-1:0]),
        .CI (w_ci),
        .S  (w_sum),
        .C  (w_co),
        .V  (w_v_unused)
      );

      // Skew (remaining operands) and deskew (finished sum chunks) flops.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_a_rest <= '0;
          r_b_rest <= '0;
          r_s_acc  <= '0;
          r_vld    <= 1'b0;
          r_c      <= 1'b0;
          r_sat    <= 1'b0;
        end else if (w_en) begin
          r_a_rest <= w_a_in[c_rw-1:c_cw];
          r_b_rest <= w_b_in[c_rw-1:c_cw];
          r_s_acc  <= w_s_acc;
          r_vld    <= w_vld;
          r_c      <= w_co;
          r_sat    <= w_sat;
        end
      end
    end else begin : g_last
      logic w_ov;

      AddCV #(.width(c_cw), .speed(speed)) u_add (
        .A  (w_a_in[c_cw-1:0]),
        .B  (w_b_in[c_cw-1:0]),
        .CI (w_ci),
        .S  (w_sum),
        .C  (w_co),
        .V  (w_ov)
      );

      // Saturation picks the bound from the wrapped sign: a wrapped
      // negative result means the true result overflowed upward.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_out_vld <= 1'b0;
          r_s       <= '0;
          r_v       <= 1'b0;
          r_c       <= 1'b0;
        end else if (w_en) begin
          r_out_vld <= w_vld;
          r_v       <= w_ov;
          r_c       <= w_co;
          if (w_sat && w_ov) begin
            r_s <= w_s_acc[width-1] ? c_max : c_min;
          end else begin
            r_s <= w_s_acc;
          end
        end
      end
    end
  end

  assign OutValid = r_out_vld;
  assign S        = r_s;
  assign V        = r_v;
  assign C        = r_c;

endmodule
`default_nettype wire
